// File: rtl/seq_detector_pkg.sv
// -----------------------------------------------------------------------------
// seq_detector_pkg
//   Shared types and constants for the serial pattern detector.
//   - state_t   : detector FSM state encoding (IDLE, FILL, ARMED)
//   - DEF_*     : default parameter values for seq_detector
//   - clamp_len : maps a requested pattern length onto 1..max_len
// -----------------------------------------------------------------------------
package seq_detector_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        ARMED = 2'd2
    } state_t;

    localparam int         DEF_MAX_LEN     = 8;
    localparam int         DEF_CNT_W       = 8;
    localparam logic [7:0] DEF_RST_PATTERN = 8'b0000_0011;
    localparam int         DEF_RST_LEN     = 2;
    localparam logic       DEF_RST_OVERLAP = 1'b0;

    // A zero-length pattern is meaningless, so it is treated as a single bit;
    // anything longer than the shift register is cut to the register width.
    function automatic int clamp_len(input int len, input int max_len);
        if (len < 1)
            return 1;
        else if (len > max_len)
            return max_len;
        else
            return len;
    endfunction

endpackage

// File: rtl/seq_detector_cnt.sv
// -----------------------------------------------------------------------------
// seq_detector_cnt
//   Saturating event counter used for the detector's match count.
//   Ports:
//     clk  in  1      clock, rising edge
//     rst  in  1      asynchronous active-low reset
//     clr  in  1      synchronous clear (wins over inc)
//     inc  in  1      count one event this cycle
//     cnt  out CNT_W  current count, holds at all-ones
// -----------------------------------------------------------------------------
module seq_detector_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    // NOTE: sequential state is only ever updated with non-blocking
    // assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && (cnt != '1))
            cnt <= cnt + CNT_W'(1);
    end

endmodule

// File: rtl/seq_detector.sv
// -----------------------------------------------------------------------------
// seq_detector
//   Runtime-programmable serial bit-pattern detector (1..MAX_LEN bits) with
//   overlapping / non-overlapping detection and a registered match pulse.
//
//   Optional feature macro: SEQ_DETECTOR_CNT_EN
//     defined   -> match_cnt is a saturating count of Y pulses
//     undefined -> match_cnt is tied to zero, no counter flops
//
//   Ports:
//     clk          in  1        clock, rising edge
//     rst          in  1        asynchronous active-low reset
//     en           in  1        detector enable (low forces IDLE)
//     cfg_load     in  1        strobe: latch cfg_* and restart detection
//     cfg_pattern  in  MAX_LEN  pattern, bit 0 = most recent bit
//     cfg_len      in  LEN_W    pattern length (clamped to 1..MAX_LEN)
//     cfg_overlap  in  1        1 = overlapping, 0 = non-overlapping
//     X            in  1        serial data bit
//     x_valid      in  1        X is sampled only when high
//     Y            out 1        one-cycle registered match pulse
//     match_cnt    out CNT_W    saturating match count
// -----------------------------------------------------------------------------
module seq_detector
    import seq_detector_pkg::*;
#(
    parameter int                 MAX_LEN     = DEF_MAX_LEN,
    parameter int                 CNT_W       = DEF_CNT_W,
    parameter logic [MAX_LEN-1:0] RST_PATTERN = MAX_LEN'(DEF_RST_PATTERN),
    parameter int                 RST_LEN     = DEF_RST_LEN,
    parameter logic               RST_OVERLAP = DEF_RST_OVERLAP,
    localparam int                LEN_W       = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               X,
    input  logic               x_valid,
    output logic               Y,
    output logic [CNT_W-1:0]   match_cnt
);

    localparam logic [LEN_W-1:0] RST_LEN_CL = LEN_W'(clamp_len(RST_LEN, MAX_LEN));

    state_t             state_q, state_d;
    logic [MAX_LEN-1:0] shift_q, shift_d;
    logic [LEN_W-1:0]   fill_q,  fill_d;
    logic [MAX_LEN-1:0] pat_q,   pat_d;
    logic [LEN_W-1:0]   len_q,   len_d;
    logic               ovl_q,   ovl_d;
    logic               y_q,     y_d;

    logic [MAX_LEN-1:0] shift_in;
    logic [MAX_LEN-1:0] len_mask;
    logic [LEN_W-1:0]   fill_inc;
    logic [LEN_W-1:0]   cfg_len_cl;
    logic               fill_full;
    logic               hit;

    // Candidate register contents if X is sampled this cycle; the match is
    // always judged on this updated value, not on the pre-edge register.
    assign shift_in   = {shift_q[MAX_LEN-2:0], X};
    assign fill_inc   = fill_q + LEN_W'(1);
    assign fill_full  = (fill_inc == len_q);
    assign cfg_len_cl = LEN_W'(clamp_len(int'(cfg_len), MAX_LEN));

    // NOTE: every signal driven in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        len_mask = '0;
        for (int i = 0; i < MAX_LEN; i++)
            len_mask[i] = (i < int'(len_q));
    end

    assign hit = (((shift_in ^ pat_q) & len_mask) == '0);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (cfg_load) begin
            state_d = en ? FILL : IDLE;
        end else if (!en) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:  state_d = FILL;
                FILL:  if (x_valid && fill_full)
                           state_d = (hit && !ovl_q) ? FILL : ARMED;
                ARMED: if (x_valid && hit && !ovl_q)
                           state_d = FILL;
                default: state_d = IDLE;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Output / datapath logic
    // -------------------------------------------------------------------------
    always_comb begin
        shift_d = shift_q;
        fill_d  = fill_q;
        pat_d   = pat_q;
        len_d   = len_q;
        ovl_d   = ovl_q;
        y_d     = 1'b0;
        if (cfg_load) begin
            // A reconfiguration discards any partial history, including a
            // bit that arrives in the same cycle.
            pat_d   = cfg_pattern;
            len_d   = cfg_len_cl;
            ovl_d   = cfg_overlap;
            shift_d = '0;
            fill_d  = '0;
        end else if (!en) begin
            fill_d = '0;
        end else begin
            unique case (state_q)
                FILL: begin
                    if (x_valid) begin
                        shift_d = shift_in;
                        fill_d  = fill_inc;
                        if (fill_full && hit) begin
                            y_d = 1'b1;
                            if (!ovl_q)
                                fill_d = '0;
                        end
                    end
                end
                ARMED: begin
                    if (x_valid) begin
                        shift_d = shift_in;
                        if (hit) begin
                            y_d = 1'b1;
                            // Non-overlapping: the next match needs len
                            // fresh bits, so refill from zero.
                            if (!ovl_q)
                                fill_d = '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: the configuration registers reset to the RST_* values rather than
    // zero, so the detector is usable straight out of reset without a load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_q <= '0;
            fill_q  <= '0;
            pat_q   <= RST_PATTERN;
            len_q   <= RST_LEN_CL;
            ovl_q   <= RST_OVERLAP;
            y_q     <= 1'b0;
        end else begin
            shift_q <= shift_d;
            fill_q  <= fill_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
            y_q     <= y_d;
        end
    end

    assign Y = y_q;

`ifdef SEQ_DETECTOR_CNT_EN
    // Counts on the same edge that raises Y, so match_cnt and Y agree.
    seq_detector_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cfg_load),
        .inc (y_d),
        .cnt (match_cnt)
    );
`else
    assign match_cnt = '0;
`endif

endmodule

// File: doc/seq_detector.md
Name: seq_detector

Overview:
- Parametrised successor to the fixed single-pattern serial state machine.
- Detects a runtime-programmable bit pattern of 1..MAX_LEN bits on a 1-bit serial input X.
- Selectable overlapping or non-overlapping detection; Moore-style registered match pulse Y.
- Sits in the state_machine-system area as the reusable serial pattern detector for control paths.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (>=2).
- LEN_W, $clog2(MAX_LEN+1), width of length fields (derived; not overridden).
- CNT_W, 8, width of the match counter.
- RST_PATTERN, 8'b0000_0011, pattern loaded at reset (LSB = most recent bit).
- RST_LEN, 2, pattern length loaded at reset.
- RST_OVERLAP, 1'b0, overlap mode loaded at reset.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- en  in  1  detector enable.
- cfg_load  in  1  one-cycle strobe; latches cfg_* fields.
- cfg_pattern  in  MAX_LEN  pattern; bit 0 = last bit received.
- cfg_len  in  LEN_W  pattern length.
- cfg_overlap  in  1  1 = overlapping, 0 = non-overlapping.
- X  in  1  serial data bit.
- x_valid  in  1  X sampled only when high.
- Y  out  1  match pulse, registered.
- match_cnt  out  CNT_W  saturating match count (optional feature).

Behaviour:
- Reset (rst=0, async): state=IDLE; shift reg=0; fill=0; Y=0; match_cnt=0; pattern/len/overlap = RST_* values.
- Length rule: cfg_len 0 loads as 1; cfg_len > MAX_LEN loads as MAX_LEN.
- FSM states: IDLE, FILL, ARMED.
  - IDLE: entered whenever en=0 (from any state); X ignored; fill cleared; shift reg holds; Y=0.
  - IDLE->FILL: en=1.
  - FILL: fill < len. Each x_valid shifts X into bit 0 and increments fill. Goes to ARMED when fill reaches len.
  - ARMED: each x_valid shifts X in. The low len bits of the updated shift reg are compared with the low len bits of the pattern.
- Match timing:
  - Y=1 for exactly one cycle, in the cycle after the clock edge that sampled the completing bit (latency 1).
  - Y=0 otherwise, including cycles with x_valid=0.
- On match, non-overlap: fill cleared, state -> FILL; the next len bits must be fresh.
- On match, overlap: state stays ARMED; the next bit can complete a new match.
- The completing bit may also finish the FILL phase; the match is evaluated on that same edge.
- cfg_load:
  - Takes priority over x_valid in the same cycle.
  - Latches the new config; clears shift reg, fill, Y and match_cnt.
  - State -> FILL if en=1, else IDLE.
- en and x_valid both high in IDLE: no bit is sampled that cycle; the transition to FILL takes one cycle.
- Reset asserted mid-stream: all outputs drop immediately, independent of clk.

Optional Feature:
- Macro SEQ_DETECTOR_CNT_EN.
- Defined: match_cnt increments by 1 on every Y pulse. It saturates at 2^CNT_W-1 (no wrap) and clears on reset or cfg_load.
- Undefined: the match_cnt port remains but is tied to 0; no counter flops are built.

Decomposition:
- Package seq_detector_pkg:
  - state enum (IDLE, FILL, ARMED).
  - length-clamp function.
  - default RST_* constants.
- One sub-module, seq_detector_cnt: saturating counter, instantiated only under SEQ_DETECTOR_CNT_EN.

Test Plan:
- Default config (pattern 2'b11, len 2, non-overlap), en=1, x_valid=1, X = 0,1,1,1,0,1,0,1,1 -> Y high only after the 3rd and 9th bits; never after the 4th.
- Overlap: cfg_load with pattern 11, len 2, overlap=1; X = 1,1,1,1 -> Y high after bits 2, 3 and 4; match_cnt=3 with the macro defined.
- Pattern 3'b101, len 3, overlap=1; X = 1,0,1,0,1 -> Y after bits 3 and 5. Same stimulus with overlap=0 -> Y after bit 3 only.
- Gaps and enable:
  - x_valid low for 4 cycles mid-pattern -> detection unaffected, Y stays 0 during the gap.
  - en dropped after 1 bit of 11, then raised -> the pattern restarts; two new 1s are needed.
- Mid-stream disturbances:
  - cfg_load in the same cycle as the completing bit -> no Y pulse; match_cnt=0; bit not shifted.
  - Async rst pulse between edges -> Y and match_cnt go to 0 without a clock edge.
- Saturation and clamping, with CNT_W=2 and SEQ_DETECTOR_CNT_EN: 5 matches -> match_cnt holds 3. cfg_len=0 -> behaves as len 1 (Y on every bit equal to pattern bit 0).
